// File: rtl/peripheral_arbiter_wb.sv
// rtl/peripheral_arbiter_wb.sv - round-robin Wishbone B3 arbiter, one slave shared by NUM_MASTERS masters
// Optional watchdog: define PERIPHERAL_ARBITER_WB_WATCHDOG_EN to terminate stalled cycles with an error.
module peripheral_arbiter_wb #(
    parameter int NUM_MASTERS = 4,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0]  m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]  m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    input  logic [NUM_MASTERS-1:0]     m_we_i,
    input  logic [NUM_MASTERS-1:0]     m_cyc_i,
    input  logic [NUM_MASTERS-1:0]     m_stb_i,
    input  logic [NUM_MASTERS*3-1:0]   m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]   m_bte_i,
    output logic [DW-1:0]              m_dat_o,
    output logic [NUM_MASTERS-1:0]     m_ack_o,
    output logic [NUM_MASTERS-1:0]     m_err_o,
    output logic [NUM_MASTERS-1:0]     m_rty_o,
    output logic [AW-1:0]              s_adr_o,
    output logic [DW-1:0]              s_dat_o,
    output logic [DW/8-1:0]            s_sel_o,
    output logic                       s_we_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic [2:0]                 s_cti_o,
    output logic [1:0]                 s_bte_o,
    input  logic [DW-1:0]              s_dat_i,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,
    input  logic                       s_rty_i,
    output logic [NUM_MASTERS-1:0]     grant_o,
    output logic                       busy_o
);

    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = DW / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_last;
    logic [GW-1:0] w_grant_nxt;
    logic [GW-1:0] w_last_nxt;
    logic [GW-1:0] w_winner;
    logic          w_any_req;
    logic          w_active;
    logic          w_wd_fire;

    // Round-robin search: first cyc requester after the previous owner wins (stb is ignored).
    always_comb begin
        w_winner  = r_last;
        w_any_req = |m_cyc_i;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            if (m_cyc_i[GW'((int'(r_last) + i) % NUM_MASTERS)]) begin
                w_winner = GW'((int'(r_last) + i) % NUM_MASTERS);
            end
        end
    end

    // Next-state logic: grant locks for the whole cyc assertion of the owner.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_grant_nxt = w_winner;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (!m_cyc_i[r_grant]) begin
                    w_last_nxt  = r_grant;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State registers; after reset master 0 is first in round-robin order.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= GW'(NUM_MASTERS - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

`ifdef PERIPHERAL_ARBITER_WB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT) + 1;

    logic [WDW-1:0] r_wd_cnt;

    assign w_wd_fire = (r_state == BUSY) && (r_wd_cnt == WDW'(TIMEOUT - 1));

    // Watchdog: count stalled strobe cycles, restart on any response, idle, or after firing.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (r_state != BUSY) || w_wd_fire || s_ack_i || s_err_i || s_rty_i) begin
            r_wd_cnt <= '0;
        end else if (s_stb_o) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign w_wd_fire = 1'b0;
`endif

    // Outputs are all-zero in IDLE and while reset is asserted.
    assign w_active = (r_state == BUSY) && !wb_rst_i;
    assign m_dat_o  = s_dat_i;
    assign busy_o   = (r_state == BUSY);

    // Request mux from the owner and response steering back to the owner only.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        grant_o = '0;
        if (w_active) begin
            s_adr_o          = m_adr_i[r_grant*AW +: AW];
            s_dat_o          = m_dat_i[r_grant*DW +: DW];
            s_sel_o          = m_sel_i[r_grant*SW +: SW];
            s_we_o           = m_we_i[r_grant];
            s_cyc_o          = m_cyc_i[r_grant] && !w_wd_fire;
            s_stb_o          = m_stb_i[r_grant] && !w_wd_fire;
            s_cti_o          = m_cti_i[r_grant*3 +: 3];
            s_bte_o          = m_bte_i[r_grant*2 +: 2];
            grant_o[r_grant] = 1'b1;
            m_ack_o[r_grant] = s_ack_i && !w_wd_fire;
            m_err_o[r_grant] = s_err_i || w_wd_fire;
            m_rty_o[r_grant] = s_rty_i && !w_wd_fire;
        end
    end

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// tb/tb_peripheral_arbiter_wb.sv - directed table-driven bench for peripheral_arbiter_wb
`timescale 1ns/1ps
module tb_peripheral_arbiter_wb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   m_adr;
    logic [N*DW-1:0]   m_dat;
    logic [N*SW-1:0]   m_sel;
    logic [N-1:0]      m_we, m_cyc, m_stb;
    logic [N*3-1:0]    m_cti;
    logic [N*2-1:0]    m_bte;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack_i, s_err_i, s_rty_i;
    logic [N-1:0]      grant_o;
    logic              busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    peripheral_arbiter_wb #(
        .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(16)
    ) dut (
        .wb_clk_i(clk),   .wb_rst_i(rst),
        .m_adr_i(m_adr),  .m_dat_i(m_dat),  .m_sel_i(m_sel),
        .m_we_i(m_we),    .m_cyc_i(m_cyc),  .m_stb_i(m_stb),
        .m_cti_i(m_cti),  .m_bte_i(m_bte),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    typedef struct {
        logic [3:0]  cyc;
        logic        ack, err, rty;
        logic [3:0]  e_grant, e_ack, e_err, e_rty;
        logic        e_scyc;
        logic [31:0] e_adr;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
        for (int k = 0; k < N; k++) m_adr[k*AW +: AW] = 32'h1000 * (k + 1);

        // cyc,   ack,  err,  rty,  grant,   ack,     err,     rty,     scyc, adr
        tbl[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[1]  = '{4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[2]  = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 32'h1000};
        tbl[3]  = '{4'b1110, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h1000};
        tbl[4]  = '{4'b1110, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[5]  = '{4'b1110, 1'b1, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b1, 32'h2000};
        tbl[6]  = '{4'b1100, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h2000};
        tbl[7]  = '{4'b1101, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[8]  = '{4'b1101, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b1, 32'h3000};
        tbl[9]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h3000};
        tbl[10] = '{4'b1001, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[11] = '{4'b1001, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b1, 32'h4000};
        tbl[12] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h4000};
        tbl[13] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0};
        tbl[14] = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 32'h1000};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h1000};
        tbl[16] = '{4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0};

        // Reset state
        tick();
        tick();
        chk("reset_grant", 64'(grant_o), 64'h0);
        chk("reset_scyc",  64'({s_cyc_o, s_stb_o}), 64'h0);
        chk("reset_busy",  64'(busy_o), 64'h0);
        rst = 1'b0;

        // Round-robin, response routing and idle isolation table
        for (int r = 0; r < 17; r++) begin
            m_cyc = tbl[r].cyc;
            m_stb = tbl[r].cyc;
            s_ack_i = tbl[r].ack;
            s_err_i = tbl[r].err;
            s_rty_i = tbl[r].rty;
            #1;
            chk($sformatf("tbl%0d_grant", r), 64'(grant_o), 64'(tbl[r].e_grant));
            chk($sformatf("tbl%0d_resp", r), 64'({m_ack_o, m_err_o, m_rty_o}),
                64'({tbl[r].e_ack, tbl[r].e_err, tbl[r].e_rty}));
            chk($sformatf("tbl%0d_scyc", r), 64'(s_cyc_o), 64'(tbl[r].e_scyc));
            chk($sformatf("tbl%0d_sadr", r), 64'(s_adr_o), 64'(tbl[r].e_adr));
            tick();
        end
        s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;

        // Single master classic write with two wait states
        m_adr[0 +: AW] = 32'h100;
        m_dat[0 +: DW] = 32'hDEADBEEF;
        m_sel[0 +: SW] = 4'hF;
        m_we = 4'b0001;
        m_cyc = 4'b0001;
        m_stb = 4'b0001;
        #1;
        chk("wr_scyc_before_edge", 64'(s_cyc_o), 64'h0);
        tick();
        chk("wr_scyc", 64'(s_cyc_o), 64'h1);
        chk("wr_req", 64'({s_adr_o, s_dat_o}), {32'h100, 32'hDEADBEEF});
        chk("wr_we_sel", 64'({s_we_o, s_sel_o}), 64'h1F);
        chk("wr_ws1_ack", 64'(m_ack_o), 64'h0);
        tick();
        chk("wr_ws2_ack", 64'(m_ack_o), 64'h0);
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("wr_ack", 64'(m_ack_o), 64'h1);
        tick();
        s_ack_i = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0;
        tick();
        chk("wr_grant_released", 64'(grant_o), 64'h0);

        // Burst lock: master 2 incrementing burst while master 1 requests
        m_cyc = 4'b0100; m_stb = 4'b0100;
        tick();
        m_cyc = 4'b0110; m_stb = 4'b0110;
        for (int b = 0; b < 8; b++) begin
            m_adr[2*AW +: AW] = 32'h3000 + 32'(4 * b);
            m_cti[2*3 +: 3] = (b == 7) ? 3'b111 : 3'b010;
            s_ack_i = 1'b1;
            s_dat_i = 32'hA000 + 32'(b);
            #1;
            chk($sformatf("burst%0d_grant", b), 64'(grant_o), 64'h4);
            chk($sformatf("burst%0d_ack", b), 64'(m_ack_o), 64'h4);
            chk($sformatf("burst%0d_adr_cti", b), 64'({s_adr_o, 1'b0, s_cti_o}),
                64'({32'h3000 + 32'(4 * b), 1'b0, ((b == 7) ? 3'b111 : 3'b010)}));
            chk($sformatf("burst%0d_dat", b), 64'(m_dat_o), 64'(32'hA000 + 32'(b)));
            tick();
        end
        s_ack_i = 1'b0;
        m_cyc = 4'b0010; m_stb = 4'b0010;
        #1;
        chk("burst_hold_at_drop", 64'(grant_o), 64'h4);
        tick();
        chk("burst_dead_cycle", 64'(grant_o), 64'h0);
        tick();
        chk("burst_next_owner", 64'(grant_o), 64'h2);

        // Reset at beat 3 of master 1 burst
        for (int b = 0; b < 3; b++) begin
            s_ack_i = 1'b1;
            #1;
            chk($sformatf("rst_beat%0d_ack", b), 64'(m_ack_o), 64'h2);
            tick();
        end
        rst = 1'b1;
        tick();
        chk("rst_mid_outputs", 64'({grant_o, m_ack_o, m_err_o, m_rty_o}), 64'h0);
        chk("rst_mid_slave", 64'({s_cyc_o, s_stb_o, busy_o}), 64'h0);
        rst = 1'b0;
        s_ack_i = 1'b0;
        m_cyc = 4'b1111; m_stb = 4'b1111;
        tick();
        chk("rst_first_winner", 64'(grant_o), 64'h1);
        m_cyc = '0; m_stb = '0;
        tick();
        tick();

        // Stalled slave: watchdog fires every TIMEOUT stall cycles, otherwise cyc/stb persist
        m_cyc = 4'b0001; m_stb = 4'b0001;
        tick();
        for (int c = 1; c <= 40; c++) begin
`ifdef PERIPHERAL_ARBITER_WB_WATCHDOG_EN
            chk($sformatf("stall%0d_stb", c), 64'({s_cyc_o, s_stb_o}),
                ((c == 16) || (c == 32)) ? 64'h0 : 64'h3);
            chk($sformatf("stall%0d_err", c), 64'(m_err_o),
                ((c == 16) || (c == 32)) ? 64'h1 : 64'h0);
`else
            chk($sformatf("stall%0d_stb", c), 64'({s_cyc_o, s_stb_o}), 64'h3);
            chk($sformatf("stall%0d_err", c), 64'(m_err_o), 64'h0);
`endif
            chk($sformatf("stall%0d_grant", c), 64'(grant_o), 64'h1);
            tick();
        end
        m_cyc = '0; m_stb = '0;
        tick();
        tick();
        chk("final_idle", 64'({grant_o, busy_o}), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
